// File: rtl/rotary_dial_tracker.sv
// Quadrature dial front end: synchronizes and debounces RotA/RotB/CenterBtn,
// decodes detents into direction and a wrapping position, and pulses Center on press.
module rotary_dial_tracker #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned COUNT_MAX       = 19
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       RotA,
    input  logic       RotB,
    input  logic       CenterBtn,
    output logic [4:0] Count,
    output logic       Right,
    output logic       Left,
    output logic       Step,
    output logic       Center
);

    localparam int unsigned NUM_IN = 3;
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned IDX_A  = 0;
    localparam int unsigned IDX_B  = 1;
    localparam int unsigned IDX_C  = 2;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]       COUNT_TOP = 5'(COUNT_MAX);

    logic [NUM_IN-1:0] raw;
    logic [NUM_IN-1:0] meta;
    logic [NUM_IN-1:0] sync;
    logic [NUM_IN-1:0] filt;
    logic [NUM_IN-1:0] filt_q;
    logic [CNT_W-1:0]  db_cnt [NUM_IN];

    logic a_rise_c;
    logic btn_rise_c;

    assign raw = {CenterBtn, RotB, RotA};

    // Two-flop synchronizers for all raw contacts.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Debounce: the filtered value follows a sample only after DEBOUNCE_CYCLES
    // consecutive disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            filt <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (sync[i] != filt[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        filt[i]   <= sync[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign a_rise_c   = filt[IDX_A] & ~filt_q[IDX_A];
    assign btn_rise_c = filt[IDX_C] & ~filt_q[IDX_C];

    // A detent is a rising edge of filtered A; filtered B picks the direction.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            filt_q <= '0;
            Count  <= '0;
            Right  <= 1'b0;
            Left   <= 1'b0;
            Step   <= 1'b0;
            Center <= 1'b0;
        end else begin
            filt_q <= filt;
            Step   <= a_rise_c;
            Center <= btn_rise_c;
            if (a_rise_c) begin
                if (!filt[IDX_B]) begin
                    Count <= (Count >= COUNT_TOP) ? 5'd0 : Count + 5'd1;
                    Right <= 1'b1;
                    Left  <= 1'b0;
                end else begin
                    Count <= (Count == 5'd0 || Count > COUNT_TOP) ? COUNT_TOP : Count - 5'd1;
                    Right <= 1'b0;
                    Left  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rotary_dial_tracker.sv
// Directed bench for rotary_dial_tracker with default parameters
// (DEBOUNCE_CYCLES=4, COUNT_MAX=19): outputs land 7 ticks after an input is driven.
module tb_rotary_dial_tracker;

    logic       Clk;
    logic       Rst;
    logic       RotA;
    logic       RotB;
    logic       CenterBtn;
    logic [4:0] Count;
    logic       Right;
    logic       Left;
    logic       Step;
    logic       Center;

    int checks     = 0;
    int errors     = 0;
    int step_cnt   = 0;
    int center_cnt = 0;
    logic [4:0] prev_count = '0;

    rotary_dial_tracker dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .RotA      (RotA),
        .RotB      (RotB),
        .CenterBtn (CenterBtn),
        .Count     (Count),
        .Right     (Right),
        .Left      (Left),
        .Step      (Step),
        .Center    (Center)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge and track pulses and invariants.
    task automatic tick();
        logic rst_at_edge;
        rst_at_edge = Rst;
        @(posedge Clk);
        #1;
        if (Step === 1'b1) step_cnt++;
        if (Center === 1'b1) center_cnt++;
        chk("right_left_exclusive", 32'(Right & Left), 32'd0);
        if (!rst_at_edge) begin
            checks++;
            assert (Count === prev_count || Step === 1'b1) else begin
                errors++;
                $error("FAIL count_change_without_step observed=%0d expected=%0d", Count, prev_count);
            end
        end
        prev_count = Count;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Full quadrature detent, each phase held 10 cycles.
    task automatic detent(input logic cw);
        if (cw) begin
            RotA = 1'b1; run(10);
            RotB = 1'b1; run(10);
            RotA = 1'b0; run(10);
            RotB = 1'b0; run(10);
        end else begin
            RotB = 1'b1; run(10);
            RotA = 1'b1; run(10);
            RotB = 1'b0; run(10);
            RotA = 1'b0; run(10);
        end
    endtask

    initial begin
        int s0;
        int c0;
        Rst = 1'b1; RotA = 1'b0; RotB = 1'b0; CenterBtn = 1'b0;

        // Reset held with random raw inputs, then idle
        for (int i = 0; i < 3; i++) begin
            RotA      = 1'($urandom_range(0, 1));
            RotB      = 1'($urandom_range(0, 1));
            CenterBtn = 1'($urandom_range(0, 1));
            tick();
            chk("reset_hold_outputs", 32'({Count, Right, Left, Step, Center}), 32'd0);
        end
        Rst = 1'b0; RotA = 1'b0; RotB = 1'b0; CenterBtn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("reset_idle_outputs", 32'({Count, Right, Left, Step, Center}), 32'd0);
        end

        // 21 clockwise detents: 1..19, 0, 1
        for (int i = 0; i < 21; i++) begin
            s0 = step_cnt;
            detent(1'b1);
            chk("cw_step_pulses", 32'(step_cnt - s0), 32'd1);
            chk("cw_count", 32'(Count), 32'((i + 1) % 20));
            chk("cw_right", 32'(Right), 32'd1);
            chk("cw_left", 32'(Left), 32'd0);
        end

        // Counter-clockwise: 1 -> 0, then 19, 18
        detent(1'b0);
        chk("ccw_count_to_zero", 32'(Count), 32'd0);
        detent(1'b0);
        chk("ccw_wrap_count", 32'(Count), 32'd19);
        chk("ccw_left", 32'(Left), 32'd1);
        chk("ccw_right", 32'(Right), 32'd0);
        s0 = step_cnt;
        detent(1'b0);
        chk("ccw_count_18", 32'(Count), 32'd18);
        chk("ccw_step_pulses", 32'(step_cnt - s0), 32'd1);

        // Bounce on A: two 3-cycle glitches, then stable high
        s0 = step_cnt;
        repeat (2) begin
            RotA = 1'b1; run(3);
            RotA = 1'b0; run(1);
        end
        RotA = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("bounce_no_early_step", 32'(Step), 32'd0);
            chk("bounce_count_hold", 32'(Count), 32'd18);
        end
        tick();
        chk("bounce_step_at_6", 32'(Step), 32'd1);
        chk("bounce_count", 32'(Count), 32'd19);
        chk("bounce_right", 32'(Right), 32'd1);
        run(10);
        RotB = 1'b1; run(10);
        RotA = 1'b0; run(10);
        RotB = 1'b0; run(10);
        chk("bounce_single_step", 32'(step_cnt - s0), 32'd1);
        chk("bounce_final_count", 32'(Count), 32'd19);

        // Center: 2-cycle bounce, 50-cycle hold, release
        c0 = center_cnt;
        s0 = step_cnt;
        CenterBtn = 1'b1; run(1);
        CenterBtn = 1'b0; run(1);
        CenterBtn = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("center_no_early", 32'(Center), 32'd0);
        end
        tick();
        chk("center_pulse_at_6", 32'(Center), 32'd1);
        run(43);
        chk("center_single_pulse", 32'(center_cnt - c0), 32'd1);
        CenterBtn = 1'b0; run(20);
        chk("center_no_release_pulse", 32'(center_cnt - c0), 32'd1);
        chk("center_no_step", 32'(step_cnt - s0), 32'd0);

        // Detent and Center aligned: 19 -> 0 with both pulses together
        c0 = center_cnt;
        RotA = 1'b1; CenterBtn = 1'b1;
        run(6);
        tick();
        chk("sim_step", 32'(Step), 32'd1);
        chk("sim_center", 32'(Center), 32'd1);
        chk("sim_count_wrap", 32'(Count), 32'd0);
        run(10);
        CenterBtn = 1'b0;
        RotB = 1'b1; run(10);
        RotA = 1'b0; run(10);
        RotB = 1'b0; run(10);
        chk("sim_center_total", 32'(center_cnt - c0), 32'd1);

        // Reset mid-operation at Count=7 with A debounce in progress
        for (int i = 0; i < 7; i++) detent(1'b1);
        chk("pre_reset_count", 32'(Count), 32'd7);
        RotA = 1'b1;
        run(4);
        Rst = 1'b1;
        tick();
        chk("midreset_count", 32'(Count), 32'd0);
        chk("midreset_right", 32'(Right), 32'd0);
        chk("midreset_left", 32'(Left), 32'd0);
        chk("midreset_step", 32'(Step), 32'd0);
        Rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("postreset_no_early_step", 32'(Step), 32'd0);
            chk("postreset_count_hold", 32'(Count), 32'd0);
        end
        tick();
        chk("postreset_step", 32'(Step), 32'd1);
        chk("postreset_count", 32'(Count), 32'd1);
        chk("postreset_right", 32'(Right), 32'd1);
        chk("postreset_left", 32'(Left), 32'd0);
        run(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rotary_dial_tracker.md
# rotary_dial_tracker

Front end for the combination lock. Converts a raw mechanical quadrature rotary dial (A/B contacts) and the raw center push-button into the clean, synchronous Right, Left, Count and Center signals that the lock state machine consumes. It synchronizes and debounces the inputs, decodes direction, and keeps a wrapping dial position counter.

## Interface
- DEBOUNCE_CYCLES, default 4: number of consecutive stable synchronized samples required before a filtered input changes. Legal range is 1..255.
- COUNT_MAX, default 19: highest dial position. Count runs 0..COUNT_MAX. Legal range is 1..31.
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  reset, synchronous, active-high.
- RotA  input  1  raw dial contact A; asynchronous and bouncy.
- RotB  input  1  raw dial contact B; asynchronous and bouncy.
- CenterBtn  input  1  raw center push-button, active-high; asynchronous and bouncy.
- Count  output  5  current dial position, 0..COUNT_MAX.
- Right  output  1  level; 1 when the most recent step was clockwise.
- Left  output  1  level; 1 when the most recent step was counter-clockwise.
- Step  output  1  one-cycle pulse on every accepted detent.
- Center  output  1  one-cycle pulse on each debounced press of the center button.

## Operation
- **Synchronizer:** RotA, RotB and CenterBtn each pass through a two-flop synchronizer. Nothing downstream uses a raw input.
- **Debouncer:** one per input.
  - Holds a filtered value and a counter of width ceil(log2(DEBOUNCE_CYCLES+1)).
  - When the synchronized sample differs from the filtered value, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES, the filtered value takes the sample and the counter clears.
  - Any cycle where the sample equals the filtered value clears the counter. Glitches shorter than DEBOUNCE_CYCLES are therefore discarded.
- **Direction decode:** one detent equals one rising edge of filtered A.
  - Filtered B = 0 at that edge: clockwise. Count increments, Right=1, Left=0, Step pulses.
  - Filtered B = 1 at that edge: counter-clockwise. Count decrements, Right=0, Left=1, Step pulses.
  - Falling edges of A and any edges of B alone cause no step.
- **Count wrap:** increment from COUNT_MAX goes to 0; decrement from 0 goes to COUNT_MAX. Count never leaves 0..COUNT_MAX.
- **Right/Left:** mutually exclusive at all times. Both are 0 from reset until the first step. After that, exactly one is 1 and it holds between steps.
- **Center:** one-cycle pulse on each rising edge of filtered CenterBtn. Holding the button produces a single pulse, and release produces none.
- **Simultaneous events:** a detent and a Center pulse in the same cycle are both reported, with no interaction or priority.
- **Reset:**
  - Asserting Rst (including mid-rotation or mid-debounce) clears all synchronizer flops, filtered values and debounce counters to 0.
  - Outputs on reset: Count=0, Right=0, Left=0, Step=0, Center=0.
  - An A level already high at reset release is treated as a new rising edge once it has been debounced.

## Timing
- Rising edge n is the first edge at which a raw input change is sampled.
- Synchronized value is valid after edge n+1.
- The filtered value changes at edge n+1+DEBOUNCE_CYCLES, assuming a stable input.
- Count, Right, Left, Step and Center update at edge n+2+DEBOUNCE_CYCLES. With the default of 4, that is 6 edges after first sampling.
- Step and Center are high for exactly one cycle per event.
- Count, Right and Left change only in the cycle Step is high.
- Maximum tracking rate is one detent per 2*(DEBOUNCE_CYCLES+2) cycles. Faster rotation may lose steps, but Count must still stay in range.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset defaults:** hold Rst for 3 cycles with random raw inputs, then release with all inputs 0.
  - Required: Count=0, Right=0, Left=0, Step=0 and Center=0 throughout, and for 20 cycles after release.
- **Clockwise steps and wrap:** 21 clean clockwise detents (A rises while B=0, each phase held 10 cycles).
  - Required: 21 Step pulses; Count goes 1,2,...,19,0,1; Right=1 and Left=0 after the first pulse.
- **Counter-clockwise steps and wrap:** from Count=0, 2 counter-clockwise detents (A rises while B=1).
  - Required: Count goes 19 then 18; Left=1 and Right=0; Step pulses coincide with the Count changes.
- **Bounce rejection:** on RotA, 3-cycle high glitches separated by 1 cycle low, then a stable high.
  - Required: exactly one step.
  - Required: the Count change occurs 6 edges after the first sample of the stable high (DEBOUNCE_CYCLES=4).
- **Center pulse:** CenterBtn bouncing for 2 cycles, then held high for 50 cycles, then released.
  - Required: exactly one Center pulse, 6 edges after the stable rise; no pulse on release.
  - Repeat with a clockwise detent aligned to the same cycle: both Step and Center pulse together.
- **Reset mid-operation:** assert Rst for 1 cycle while Count=7 and a debounce counter is partially filled.
  - Required: Count=0 and Right=Left=0 on the next cycle; the pending change is not reported until it re-debounces.
